// File: rtl/quad_pkg.sv
// Shared definitions for the quadrature decoder: FSM states, Gray-code phase
// constants ({A,B}) and the forward-step helper used by decode and bench.
package quad_pkg;

    typedef enum logic {
        ST_INIT = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    localparam logic [1:0] Q00 = 2'b00;
    localparam logic [1:0] Q10 = 2'b10;
    localparam logic [1:0] Q11 = 2'b11;
    localparam logic [1:0] Q01 = 2'b01;

    // Phase reached by one count-up step (A leads B): 00 -> 10 -> 11 -> 01 -> 00.
    function automatic logic [1:0] next_up(input logic [1:0] s);
        logic [1:0] n;
        case (s)
            Q00:     n = Q10;
            Q10:     n = Q11;
            Q11:     n = Q01;
            default: n = Q00;
        endcase
        return n;
    endfunction

endpackage

// File: rtl/quad_chan_filter.sv
// One encoder channel: metastability synchroniser followed by a stability
// filter. A new synced level is accepted only after FILTER consecutive cycles
// of disagreement with the current output; i_bypass makes the output follow the
// synced level directly (used while the decoder initialises).
module quad_chan_filter #(
    parameter int SYNC_STAGES = 2,
    parameter int FILTER      = 3
) (
    input  logic clk,
    input  logic reset,
    input  logic i_async,
    input  logic i_bypass,
    output logic o_level
);

    localparam int CW = (FILTER < 2) ? 1 : $clog2(FILTER + 1);

    logic [SYNC_STAGES-1:0] r_sync;
    logic [CW-1:0]          r_cnt;
    logic                   r_level;
    logic                   w_synced;

    assign w_synced = r_sync[SYNC_STAGES-1];
    assign o_level  = r_level;

    // Shift the asynchronous pin through the synchroniser chain.
    // NOTE: clocked state uses non-blocking assignments so every flop samples
    // the pre-edge value of its neighbour; blocking here would collapse the chain.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_sync <= '0;
        end else begin
            r_sync <= {r_sync[SYNC_STAGES-2:0], i_async};
        end
    end

    // Accept a new level only once it has disagreed for FILTER cycles in a row.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_cnt   <= '0;
            r_level <= 1'b0;
        end else if (i_bypass) begin
            r_level <= w_synced;
            r_cnt   <= '0;
        end else if (w_synced == r_level) begin
            r_cnt   <= '0;
        end else if (r_cnt == CW'(FILTER - 1)) begin
            r_level <= w_synced;
            r_cnt   <= '0;
        end else begin
            r_cnt   <= r_cnt + CW'(1);
        end
    end

endmodule

// File: rtl/quad_decoder.sv
// Quadrature decoder top: filters both channels, holds off decoding while the
// pipeline fills after reset, then turns single-bit Gray transitions into a
// step strobe, direction and wrapping position; double-bit jumps set err.
module quad_decoder
    import quad_pkg::*;
#(
    parameter int WIDTH       = 16,
    parameter int SYNC_STAGES = 2,
    parameter int FILTER      = 3
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             a_in,
    input  logic             b_in,
    input  logic             enable,
    input  logic             clear,
    output logic             step,
    output logic             dir,
    output logic [WIDTH-1:0] position,
    output logic             err
);

    // Decoding is suppressed until the synchroniser, the bypassed filter and
    // prev all hold the encoder's resting phase.
    localparam int INIT_LEN = SYNC_STAGES + 2;
    localparam int ICW      = $clog2(INIT_LEN + 1);

    state_t           r_state;
    logic [ICW-1:0]   r_init_cnt;
    logic [1:0]       r_prev;
    logic             r_step;
    logic             r_dir;
    logic             r_err;
    logic [WIDTH-1:0] r_pos;

    logic       w_a_filt;
    logic       w_b_filt;
    logic       w_bypass;
    logic [1:0] w_cur;
    logic       w_up;
    logic       w_down;
    logic       w_illegal;

    assign w_bypass = (r_state == ST_INIT);

    quad_chan_filter #(.SYNC_STAGES(SYNC_STAGES), .FILTER(FILTER)) u_filt_a (
        .clk      (clk),
        .reset    (reset),
        .i_async  (a_in),
        .i_bypass (w_bypass),
        .o_level  (w_a_filt)
    );

    quad_chan_filter #(.SYNC_STAGES(SYNC_STAGES), .FILTER(FILTER)) u_filt_b (
        .clk      (clk),
        .reset    (reset),
        .i_async  (b_in),
        .i_bypass (w_bypass),
        .o_level  (w_b_filt)
    );

    assign w_cur     = {w_a_filt, w_b_filt};
    assign w_up      = (w_cur == next_up(r_prev));
    assign w_down    = (r_prev == next_up(w_cur));
    assign w_illegal = ((w_cur ^ r_prev) == 2'b11);

    assign step     = r_step;
    assign dir      = r_dir;
    assign position = r_pos;
    assign err      = r_err;

    // Hold INIT for a fixed number of cycles after reset release, then run.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state    <= ST_INIT;
            r_init_cnt <= '0;
        end else if (r_state == ST_INIT) begin
            if (r_init_cnt == ICW'(INIT_LEN - 1)) begin
                r_state <= ST_RUN;
            end else begin
                r_init_cnt <= r_init_cnt + ICW'(1);
            end
        end
    end

    // Track the previous filtered phase every cycle, including INIT and enable=0.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_prev <= Q00;
        end else begin
            r_prev <= w_cur;
        end
    end

    // Decode transitions into step/dir/position/err; clear overrides position and err.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_step <= 1'b0;
            r_dir  <= 1'b0;
            r_err  <= 1'b0;
            r_pos  <= '0;
        end else begin
            r_step <= 1'b0;
            if (r_state == ST_RUN) begin
                if (w_up || w_down) begin
                    r_dir <= w_up;
                    if (enable) begin
                        r_step <= 1'b1;
                        r_pos  <= w_up ? r_pos + WIDTH'(1) : r_pos - WIDTH'(1);
                    end
                end else if (w_illegal) begin
                    r_err <= 1'b1;
                end
            end
            if (clear) begin
                r_pos <= '0;
                r_err <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_quad_decoder.sv
// Self-checking bench for quad_decoder: stimulus tasks update a behavioural
// encoder model and queue the expected step events; a monitor pops and
// compares whenever the DUT strobes step. Quiet-time checks cover held state.
module tb_quad_decoder;
    import quad_pkg::*;

    localparam int WIDTH   = 16;
    localparam int MOD     = 1 << WIDTH;
    localparam int LATENCY = 6;

    logic             clk = 1'b0;
    logic             reset;
    logic             a_in;
    logic             b_in;
    logic             enable;
    logic             clear;
    logic             step;
    logic             dir;
    logic [WIDTH-1:0] position;
    logic             err;

    quad_decoder #(.WIDTH(WIDTH), .SYNC_STAGES(2), .FILTER(3)) dut (
        .clk      (clk),
        .reset    (reset),
        .a_in     (a_in),
        .b_in     (b_in),
        .enable   (enable),
        .clear    (clear),
        .step     (step),
        .dir      (dir),
        .position (position),
        .err      (err)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc++;

    int total = 0;
    int bad   = 0;

    typedef struct {
        int               at;
        logic             d;
        logic [WIDTH-1:0] p;
    } exp_t;

    exp_t exp_q[$];

    // Behavioural encoder/decoder model.
    logic [1:0] cur;
    int         m_pos;
    logic       m_dir;
    logic       m_err;
    logic       m_en;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
        total++;
        if (act !== expv) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h (t=%0t)", name, act, expv, $time);
        end
    endtask

    task automatic wait_cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    function automatic logic [1:0] prev_of(input logic [1:0] s);
        logic [1:0] r;
        r = 2'b00;
        for (int i = 0; i < 4; i++) begin
            if (next_up(2'(i)) == s) r = 2'(i);
        end
        return r;
    endfunction

    task automatic drive(input logic [1:0] s);
        a_in = s[1];
        b_in = s[0];
        cur  = s;
    endtask

    task automatic push_exp(input logic d);
        exp_t e;
        e.at = cyc + LATENCY;
        e.d  = d;
        e.p  = WIDTH'(m_pos);
        exp_q.push_back(e);
    endtask

    // One legal encoder step, held for 'hold' cycles.
    task automatic move(input bit up, input int hold);
        logic [1:0] nxt;
        nxt = up ? next_up(cur) : prev_of(cur);
        drive(nxt);
        m_dir = up;
        if (m_en) begin
            m_pos = up ? (m_pos + 1) % MOD : (m_pos + MOD - 1) % MOD;
            push_exp(up);
        end
        wait_cyc(hold);
    endtask

    task automatic glitch(input bit on_a, input int len);
        if (on_a) a_in = ~cur[1];
        else      b_in = ~cur[0];
        wait_cyc(len);
        drive(cur);
        wait_cyc(5);
    endtask

    task automatic illegal_jump(input int hold);
        drive(cur ^ 2'b11);
        m_err = 1'b1;
        wait_cyc(hold);
    endtask

    task automatic pulse_clear();
        clear = 1'b1;
        wait_cyc(1);
        clear = 1'b0;
        m_pos = 0;
        m_err = 1'b0;
    endtask

    task automatic quiet_check(input string tag);
        wait_cyc(9);
        check({tag, "_step"}, 32'(step), 32'(1'b0));
        check({tag, "_pos"}, 32'(position), 32'(m_pos));
        check({tag, "_dir"}, 32'(dir), 32'(m_dir));
        check({tag, "_err"}, 32'(err), 32'(m_err));
        check({tag, "_pending"}, 32'(exp_q.size()), 32'd0);
    endtask

    task automatic check_zeroed(input string tag);
        check({tag, "_step"}, 32'(step), 32'd0);
        check({tag, "_pos"}, 32'(position), 32'd0);
        check({tag, "_dir"}, 32'(dir), 32'd0);
        check({tag, "_err"}, 32'(err), 32'd0);
    endtask

    task automatic model_reset();
        exp_q.delete();
        m_pos = 0;
        m_dir = 1'b0;
        m_err = 1'b0;
    endtask

    // Monitor: every step strobe must match the oldest expected event.
    initial begin
        forever begin
            @(negedge clk);
            if (reset === 1'b0 && step === 1'b1) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_step", 32'd1, 32'd0);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    check("step_latency", 32'(cyc), 32'(e.at));
                    check("step_dir", 32'(dir), 32'(e.d));
                    check("step_pos", 32'(position), 32'(e.p));
                end
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset  = 1'b1;
        enable = 1'b1;
        clear  = 1'b0;
        m_en   = 1'b1;
        drive(Q00);
        model_reset();
        wait_cyc(2);
        check_zeroed("reset");
        reset = 1'b0;
        wait_cyc(10);

        // 1: four full up cycles from rest.
        for (int i = 0; i < 16; i++) move(1'b1, 10);
        quiet_check("up16");

        // 2: reverse from zero wraps to all-ones, then back up across the wrap.
        pulse_clear();
        for (int i = 0; i < 4; i++) move(1'b0, 10);
        quiet_check("down4");
        for (int i = 0; i < 4; i++) move(1'b1, 10);
        quiet_check("wrap_up");

        // 3: short glitches on either channel are discarded.
        move(1'b1, 10);
        glitch(1'b1, 2);
        glitch(1'b0, 1);
        quiet_check("glitch");

        // 4: double-bit jump sets err; clear drops err and position.
        illegal_jump(10);
        quiet_check("illegal");
        pulse_clear();
        quiet_check("cleared");

        // Clear coincident with a legal step: step and dir still update, position 0.
        move(1'b1, 8);
        drive(next_up(cur));
        m_dir = 1'b1;
        m_pos = 0;
        m_err = 1'b0;
        push_exp(1'b1);
        wait_cyc(LATENCY - 1);
        clear = 1'b1;
        wait_cyc(1);
        clear = 1'b0;
        quiet_check("clear_step");

        // 5: leave reset with the encoder resting at 11.
        reset = 1'b1;
        drive(Q11);
        model_reset();
        wait_cyc(3);
        reset = 1'b0;
        quiet_check("init11");
        move(1'b1, 10);
        quiet_check("init11_step");

        // 6: enable=0 suppresses steps but dir follows; no burst afterwards.
        enable = 1'b0;
        m_en   = 1'b0;
        for (int i = 0; i < 3; i++) move(1'b1, 8);
        move(1'b0, 8);
        quiet_check("disabled");
        enable = 1'b1;
        m_en   = 1'b1;
        quiet_check("reenabled");
        move(1'b1, 10);
        move(1'b1, 3);
        reset = 1'b1;
        #1;
        check_zeroed("mid_reset");
        model_reset();
        wait_cyc(3);
        reset = 1'b0;
        quiet_check("post_reset");

        // Randomised encoder activity.
        for (int n = 0; n < 300; n++) begin
            int r;
            r = int'($urandom_range(0, 99));
            if (r < 70) begin
                move(1'($urandom_range(0, 1)), int'($urandom_range(4, 12)));
            end else if (r < 80) begin
                glitch(1'($urandom_range(0, 1)), int'($urandom_range(1, 2)));
            end else if (r < 85) begin
                illegal_jump(int'($urandom_range(4, 10)));
            end else if (r < 90) begin
                wait_cyc(7);
                enable = ~enable;
                m_en   = enable;
            end else if (r < 95) begin
                wait_cyc(7);
                pulse_clear();
            end else begin
                quiet_check("rand");
            end
        end
        enable = 1'b1;
        m_en   = 1'b1;
        quiet_check("final");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
